trend_detector_p: RTL

Parametrised successor to the single-step 4-bit incr/decr/error detector. Classifies each accepted sample of a valid-qualified data stream against the previous accepted sample, using a runtime step size and an optional modular (wrap-around) compare. Adds a hold (equal) result, a monotonic run-length tracker with a threshold flag, and a saturating error counter. Sits directly after the stimulus/data source as a stream-integrity monitor.

---
 rtl/trend_pkg.sv | 28 ++
 rtl/trend_classify.sv | 38 +++
 rtl/trend_detector_p.sv | 104 ++++++++++
 3 files changed

// File: rtl/trend_pkg.sv
// Shared types and helpers for the trend detector slice.
// Holds FSM/result encodings and the modular-difference helper.
package trend_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    RES_INCR = 2'd0,
    RES_DECR = 2'd1,
    RES_HOLD = 2'd2,
    RES_ERR  = 2'd3
  } res_t;

  localparam int MAXW = 64;

  // (a - b) mod 2^w, for any w up to MAXW
  function automatic logic [MAXW-1:0] mod_diff(input logic [MAXW-1:0] a,
                                               input logic [MAXW-1:0] b,
                                               input int w);
    logic [MAXW-1:0] mask;
    mask = (w >= MAXW) ? {MAXW{1'b1}} : ((MAXW'(1) << w) - MAXW'(1));
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/trend_classify.sv
// Combinational classifier: sample vs previous sample under a given step.
// Zero latency; no flow control (pure function of its inputs).
module trend_classify
  import trend_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] step,
  input  logic             wrap,
  output res_t             res
);

  logic [WIDTH-1:0] fwd;
  logic [WIDTH-1:0] bwd;
  logic [WIDTH-1:0] nstep;

  always_comb begin
    fwd   = WIDTH'(mod_diff(MAXW'(data), MAXW'(prev), WIDTH));
    bwd   = WIDTH'(mod_diff(MAXW'(prev), MAXW'(data), WIDTH));
    nstep = WIDTH'(mod_diff(MAXW'(0), MAXW'(step), WIDTH));
    res   = RES_ERR;
    // A zero step never yields hold: every sample is an error then.
    if (step != '0) begin
      if (wrap) begin
        if (fwd == step)       res = RES_INCR;
        else if (fwd == nstep) res = RES_DECR;
        else if (fwd == '0)    res = RES_HOLD;
      end else begin
        if (data > prev && fwd == step)      res = RES_INCR;
        else if (data < prev && bwd == step) res = RES_DECR;
        else if (data == prev)               res = RES_HOLD;
      end
    end
  end

endmodule

// File: rtl/trend_detector_p.sv
// Stream-integrity monitor: classifies each accepted sample against the previous one.
// Results register one cycle after acceptance; never stalls the source (no ready).
module trend_detector_p
  import trend_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RUN_W      = 8,
  parameter int RUN_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic             cfg_wrap,
  input  logic             flush,
  input  logic             clear_cnt,
  output logic             out_valid,
  output logic             incr,
  output logic             decr,
  output logic             hold,
  output logic             error,
  output logic [RUN_W-1:0] run_len,
  output logic             run_hit,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] prev;
  res_t             res;
  logic             result_now;
  logic             err_now;
  logic [RUN_W-1:0] run_nxt;

  trend_classify #(.WIDTH(WIDTH)) u_classify (
    .prev (prev),
    .data (in_data),
    .step (cfg_step),
    .wrap (cfg_wrap),
    .res  (res)
  );

  assign result_now = in_valid && !flush && (state == ST_TRACK);
  assign err_now    = result_now && (res == RES_ERR);

  // A run continues only if the last result was the same direction and no
  // hold/error/flush has zeroed run_len since.
  always_comb begin
    run_nxt = '0;
    unique case (res)
      RES_INCR: run_nxt = (incr && run_len != '0)
                          ? ((run_len == RUN_MAX) ? run_len : run_len + 1'b1)
                          : RUN_W'(1);
      RES_DECR: run_nxt = (decr && run_len != '0)
                          ? ((run_len == RUN_MAX) ? run_len : run_len + 1'b1)
                          : RUN_W'(1);
      default:  run_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      prev      <= '0;
      out_valid <= 1'b0;
      incr      <= 1'b0;
      decr      <= 1'b0;
      hold      <= 1'b0;
      error     <= 1'b0;
      run_len   <= '0;
      run_hit   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        state   <= ST_EMPTY;
        run_len <= '0;
        run_hit <= 1'b0;
      end else if (in_valid) begin
        prev  <= in_data;
        state <= ST_TRACK;
        if (state == ST_TRACK) begin
          out_valid <= 1'b1;
          incr      <= (res == RES_INCR);
          decr      <= (res == RES_DECR);
          hold      <= (res == RES_HOLD);
          error     <= (res == RES_ERR);
          run_len   <= run_nxt;
          run_hit   <= (run_nxt >= RUN_W'(RUN_THRESH));
        end
      end

      if (clear_cnt)
        err_cnt <= err_now ? CNT_W'(1) : '0;
      else if (err_now && err_cnt != CNT_MAX)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
